// File: rtl/signal_query_sequencer_if.sv
// Request/response bus between a trace consumer and the signal query sequencer.
// The consumer side uses the master modport and the sequencer uses the slave modport.
interface signal_query_sequencer_if;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [31:0] req_arg0;
    logic [31:0] req_arg1;
    logic [2:0]  req_flags;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [2:0]  rsp_op;
    logic [31:0] rsp_data0;
    logic [31:0] rsp_data1;
    logic        rsp_err;

    modport master (
        output req_valid, req_op, req_arg0, req_arg1, req_flags, rsp_ready,
        input  req_ready, rsp_valid, rsp_op, rsp_data0, rsp_data1, rsp_err
    );

    modport slave (
        input  req_valid, req_op, req_arg0, req_arg1, req_flags, rsp_ready,
        output req_ready, rsp_valid, rsp_op, rsp_data0, rsp_data1, rsp_err
    );
endinterface

// File: rtl/signal_query_sequencer.sv
// Query initiator for the signal tracker. Requests are buffered in a small FIFO
// and executed one at a time. Each query sets up the tracker arguments, fires one
// strobe, waits a settle window, and then returns the captured result.
// The reset input rst_n is active-high even though its name ends in _n.
module signal_query_sequencer #(
    parameter int TRACKED_SIGNAL_WIDTH = 1,
    parameter int FIFO_DEPTH           = 2,
    parameter int SETTLE_CYCLES        = 1
) (
    input  logic                            clk,
    input  logic                            rst_n,
    signal_query_sequencer_if.slave         qif,
    output logic                            busy,
    output logic [31:0]                     value_in,
    output logic [31:0]                     range_lo,
    output logic [31:0]                     range_hi,
    output logic [31:0]                     previous_end_o,
    output logic [31:0]                     cycles_back_to_recall,
    output logic                            ready_flag,
    output logic                            ex_ready_flag,
    output logic                            data_mem_req_flag,
    output logic                            recalculate_time,
    output logic                            recalculate_range,
    output logic                            recalculate_single_cycle,
    output logic                            recalculate_back_cycle,
    output logic                            update_end,
    input  logic signed [31:0]              time_start_i,
    input  logic signed [31:0]              time_end_i,
    input  logic                            range_i,
    input  logic signed [31:0]              single_cycle_i,
    input  logic [TRACKED_SIGNAL_WIDTH-1:0] signal_recall_i
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

    localparam logic [2:0] OP_TIME       = 3'd0;
    localparam logic [2:0] OP_RANGE      = 3'd1;
    localparam logic [2:0] OP_SINGLE     = 3'd2;
    localparam logic [2:0] OP_RECALL     = 3'd3;
    localparam logic [2:0] OP_UPDATE_END = 3'd4;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        STROBE,
        SETTLE,
        RESP
    } state_e;

    typedef struct packed {
        logic [2:0]  op;
        logic [31:0] arg0;
        logic [31:0] arg1;
        logic [2:0]  flags;
    } req_t;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   settleCnt_q, settleCnt_d;

    req_t               fifoMem_q [FIFO_DEPTH];
    logic [PTR_W:0]     wrPtr_q, rdPtr_q;
    logic               fifoEmpty, fifoFull, push, pop;
    req_t               head;
    logic               headIllegal;

    logic               captureResult, captureUpdateEnd;

    logic [2:0]         op_q;
    logic [31:0]        valueIn_q, rangeLo_q, rangeHi_q, prevEnd_q, cyclesBack_q;
    logic               readyFlag_q, exReadyFlag_q, dataMemReqFlag_q;
    logic [2:0]         rspOp_q;
    logic [31:0]        rspData0_q, rspData1_q;
    logic               rspErr_q;

    // The extra pointer bit separates a full FIFO from an empty one when the indices match.
    assign fifoEmpty   = (wrPtr_q == rdPtr_q);
    assign fifoFull    = (wrPtr_q[PTR_W] != rdPtr_q[PTR_W]) &&
                         (wrPtr_q[PTR_W-1:0] == rdPtr_q[PTR_W-1:0]);
    assign push        = qif.req_valid && qif.req_ready;
    assign head        = fifoMem_q[rdPtr_q[PTR_W-1:0]];
    assign headIllegal = (head.op > OP_UPDATE_END);

    assign qif.req_ready = !fifoFull && !rst_n;
    assign qif.rsp_valid = (state_q == RESP);
    assign qif.rsp_op    = rspOp_q;
    assign qif.rsp_data0 = rspData0_q;
    assign qif.rsp_data1 = rspData1_q;
    assign qif.rsp_err   = rspErr_q;
    assign busy          = (state_q != IDLE) || !fifoEmpty;

    assign value_in              = valueIn_q;
    assign range_lo              = rangeLo_q;
    assign range_hi              = rangeHi_q;
    assign previous_end_o        = prevEnd_q;
    assign cycles_back_to_recall = cyclesBack_q;
    assign ready_flag            = readyFlag_q;
    assign ex_ready_flag         = exReadyFlag_q;
    assign data_mem_req_flag     = dataMemReqFlag_q;

    // Request storage is data only, so it needs no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            fifoMem_q[wrPtr_q[PTR_W-1:0]] <= '{op:    qif.req_op,
                                               arg0:  qif.req_arg0,
                                               arg1:  qif.req_arg1,
                                               flags: qif.req_flags};
        end
    end

    // FIFO pointers advance on push and pop and wrap through the extra bit.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
        end else begin
            if (push) wrPtr_q <= wrPtr_q + 1'b1;
            if (pop)  rdPtr_q <= rdPtr_q + 1'b1;
        end
    end

    // State register and settle counter.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q     <= IDLE;
            settleCnt_q <= '0;
        end else begin
            state_q     <= state_d;
            settleCnt_q <= settleCnt_d;
        end
    end

    // Next-state logic, pop and capture controls, and the single strobe decoded from STROBE.
    always_comb begin
        state_d                  = state_q;
        settleCnt_d              = settleCnt_q;
        pop                      = 1'b0;
        captureResult            = 1'b0;
        captureUpdateEnd         = 1'b0;
        recalculate_time         = 1'b0;
        recalculate_range        = 1'b0;
        recalculate_single_cycle = 1'b0;
        recalculate_back_cycle   = 1'b0;
        update_end               = 1'b0;

        case (state_q)
            IDLE: begin
                if (!fifoEmpty) begin
                    pop     = 1'b1;
                    state_d = headIllegal ? RESP : SETUP;
                end
            end
            SETUP: begin
                state_d = STROBE;
            end
            STROBE: begin
                case (op_q)
                    OP_TIME:       recalculate_time         = 1'b1;
                    OP_RANGE:      recalculate_range        = 1'b1;
                    OP_SINGLE:     recalculate_single_cycle = 1'b1;
                    OP_RECALL:     recalculate_back_cycle   = 1'b1;
                    OP_UPDATE_END: update_end               = 1'b1;
                    default:       ;
                endcase
                if (op_q == OP_UPDATE_END) begin
                    captureUpdateEnd = 1'b1;
                    state_d          = RESP;
                end else begin
                    settleCnt_d = '0;
                    state_d     = SETTLE;
                end
            end
            SETTLE: begin
                if (settleCnt_q == CNT_LAST) begin
                    captureResult = 1'b1;
                    state_d       = RESP;
                end else begin
                    settleCnt_d = settleCnt_q + CNT_W'(1);
                end
            end
            RESP: begin
                if (qif.rsp_ready) state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Load tracker arguments at pop so they are stable through SETUP, and capture results into the response.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            op_q             <= '0;
            valueIn_q        <= '0;
            rangeLo_q        <= '0;
            rangeHi_q        <= '0;
            prevEnd_q        <= '0;
            cyclesBack_q     <= '0;
            readyFlag_q      <= 1'b0;
            exReadyFlag_q    <= 1'b0;
            dataMemReqFlag_q <= 1'b0;
            rspOp_q          <= '0;
            rspData0_q       <= '0;
            rspData1_q       <= '0;
            rspErr_q         <= 1'b0;
        end else begin
            if (pop) begin
                op_q       <= head.op;
                rspOp_q    <= head.op;
                rspErr_q   <= headIllegal;
                rspData0_q <= '0;
                rspData1_q <= '0;
                if (!headIllegal) begin
                    readyFlag_q   <= head.flags[0];
                    exReadyFlag_q <= head.flags[1];
                end
                case (head.op)
                    OP_TIME: begin
                        valueIn_q        <= head.arg0;
                        dataMemReqFlag_q <= head.flags[2];
                    end
                    OP_RANGE, OP_SINGLE: begin
                        rangeLo_q <= head.arg0;
                        rangeHi_q <= head.arg1;
                    end
                    OP_RECALL:     cyclesBack_q <= head.arg0;
                    OP_UPDATE_END: prevEnd_q    <= head.arg0;
                    default:       ;
                endcase
            end
            if (captureUpdateEnd) begin
                rspData0_q <= prevEnd_q;
            end
            if (captureResult) begin
                case (op_q)
                    OP_TIME: begin
                        rspData0_q <= time_start_i;
                        rspData1_q <= time_end_i;
                    end
                    OP_RANGE:  rspData0_q <= {31'd0, range_i};
                    OP_SINGLE: rspData0_q <= single_cycle_i;
                    OP_RECALL: rspData0_q <= 32'(signal_recall_i);
                    default:   ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_signal_query_sequencer.sv
// Directed testbench for signal_query_sequencer with hand-computed expectations.
// The tracker is modelled as constant result inputs.
module tb_signal_query_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        rangeI = 1'b1;
    logic [31:0] timeStartI = 32'd10;
    logic [31:0] timeEndI = 32'd12;
    logic [31:0] singleCycleI = 32'hFFFF_FFFD;
    logic [0:0]  signalRecallI = 1'b1;

    logic        busy;
    logic [31:0] valueIn, rangeLo, rangeHi, previousEnd, cyclesBack;
    logic        readyFlag, exReadyFlag, dataMemReqFlag;
    logic        recalcTime, recalcRange, recalcSingle, recalcBack, updateEnd;

    int assertCount = 0;
    int failCount = 0;

    int timeStrobes = 0;
    int singleStrobes = 0;
    int recallStrobes = 0;
    int updateStrobes = 0;
    int overlapCount = 0;
    int rspValidCycles = 0;
    logic [31:0] rangeLoLog [$];

    signal_query_sequencer_if qif ();

    signal_query_sequencer #(
        .TRACKED_SIGNAL_WIDTH (1),
        .FIFO_DEPTH           (2),
        .SETTLE_CYCLES        (1)
    ) dut (
        .clk                      (clk),
        .rst_n                    (rst_n),
        .qif                      (qif),
        .busy                     (busy),
        .value_in                 (valueIn),
        .range_lo                 (rangeLo),
        .range_hi                 (rangeHi),
        .previous_end_o           (previousEnd),
        .cycles_back_to_recall    (cyclesBack),
        .ready_flag               (readyFlag),
        .ex_ready_flag            (exReadyFlag),
        .data_mem_req_flag        (dataMemReqFlag),
        .recalculate_time         (recalcTime),
        .recalculate_range        (recalcRange),
        .recalculate_single_cycle (recalcSingle),
        .recalculate_back_cycle   (recalcBack),
        .update_end               (updateEnd),
        .time_start_i             (timeStartI),
        .time_end_i               (timeEndI),
        .range_i                  (rangeI),
        .single_cycle_i           (singleCycleI),
        .signal_recall_i          (signalRecallI)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Strobe and response monitor sampled on the falling edge, where the tracker samples.
    always @(negedge clk) begin
        if (recalcTime)   timeStrobes++;
        if (recalcSingle) singleStrobes++;
        if (recalcBack)   recallStrobes++;
        if (updateEnd)    updateStrobes++;
        if (recalcRange)  rangeLoLog.push_back(rangeLo);
        if ((int'(recalcTime) + int'(recalcRange) + int'(recalcSingle) +
             int'(recalcBack) + int'(updateEnd)) > 1) overlapCount++;
        if (qif.rsp_valid) rspValidCycles++;
    end

    // Global time limit so the bench always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    // Offers one request and returns 1 time unit after the accepting edge.
    task automatic applyStimulus(input logic [2:0] op, input logic [31:0] arg0,
                                 input logic [31:0] arg1, input logic [2:0] flags);
        logic accepted;
        int   waitCycles;
        accepted       = 1'b0;
        waitCycles     = 0;
        qif.req_op     = op;
        qif.req_arg0   = arg0;
        qif.req_arg1   = arg1;
        qif.req_flags  = flags;
        qif.req_valid  = 1'b1;
        while (!accepted && waitCycles < 50) begin
            accepted = qif.req_ready;
            stepCycle();
            waitCycles++;
        end
        qif.req_valid = 1'b0;
        checkOutput("req_accepted", accepted, 1'b1);
    endtask

    task automatic waitRsp(input string tag);
        int   n;
        logic timedOut;
        n = 0;
        while (!qif.rsp_valid && n < 40) begin
            stepCycle();
            n++;
        end
        timedOut = !qif.rsp_valid;
        checkOutput(tag, timedOut, 1'b0);
    endtask

    task automatic acceptRsp();
        qif.rsp_ready = 1'b1;
        stepCycle();
        qif.rsp_ready = 1'b0;
    endtask

    initial begin
        int strobeSnapshot;
        qif.req_valid = 1'b0;
        qif.req_op    = '0;
        qif.req_arg0  = '0;
        qif.req_arg1  = '0;
        qif.req_flags = '0;
        qif.rsp_ready = 1'b0;

        // Reset held for three cycles
        repeat (3) stepCycle();
        checkOutput("rst_req_ready", qif.req_ready, 1'b0);
        checkOutput("rst_rsp_valid", qif.rsp_valid, 1'b0);
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_strobes", {recalcTime, recalcRange, recalcSingle, recalcBack, updateEnd}, 5'b0);
        checkOutput("rst_args", {valueIn, rangeLo, previousEnd}, 96'b0);
        checkOutput("rst_rsp_fields", {qif.rsp_op, qif.rsp_data0, qif.rsp_data1, qif.rsp_err}, 68'b0);
        rst_n = 1'b0;
        stepCycle();
        checkOutput("post_rst_req_ready", qif.req_ready, 1'b1);
        checkOutput("post_rst_busy", busy, 1'b0);

        // TIME query: arguments lead the strobe by one cycle, response after edge N+4
        applyStimulus(3'd0, 32'd3, 32'd0, 3'b001);
        stepCycle();
        checkOutput("time_value_in", valueIn, 32'd3);
        checkOutput("time_ready_flag", readyFlag, 1'b1);
        checkOutput("time_ex_ready_flag", exReadyFlag, 1'b0);
        checkOutput("time_strobe_setup", recalcTime, 1'b0);
        checkOutput("time_busy", busy, 1'b1);
        stepCycle();
        checkOutput("time_strobe_high", recalcTime, 1'b1);
        stepCycle();
        checkOutput("time_strobe_low", recalcTime, 1'b0);
        checkOutput("time_rsp_early", qif.rsp_valid, 1'b0);
        stepCycle();
        checkOutput("time_rsp_valid", qif.rsp_valid, 1'b1);
        checkOutput("time_data0", qif.rsp_data0, 32'd10);
        checkOutput("time_data1", qif.rsp_data1, 32'd12);
        checkOutput("time_err", qif.rsp_err, 1'b0);
        checkOutput("time_op", qif.rsp_op, 3'd0);
        stepCycle();
        checkOutput("time_rsp_held", qif.rsp_valid, 1'b1);
        acceptRsp();
        checkOutput("time_rsp_done", qif.rsp_valid, 1'b0);
        checkOutput("time_strobe_count", timeStrobes, 1);

        // Back-pressure: three RANGE requests with rsp_ready low
        applyStimulus(3'd1, 32'd100, 32'd200, 3'b000);
        applyStimulus(3'd1, 32'd101, 32'd201, 3'b000);
        applyStimulus(3'd1, 32'd102, 32'd202, 3'b000);
        checkOutput("bp_req_ready_low", qif.req_ready, 1'b0);
        repeat (10) stepCycle();
        checkOutput("bp_req_ready_still_low", qif.req_ready, 1'b0);
        checkOutput("bp_single_range_pulse", rangeLoLog.size(), 1);
        for (int i = 0; i < 3; i++) begin
            waitRsp("bp_rsp_timeout");
            checkOutput("bp_rsp_op", qif.rsp_op, 3'd1);
            checkOutput("bp_rsp_data0", qif.rsp_data0, 32'd1);
            checkOutput("bp_rsp_data1", qif.rsp_data1, 32'd0);
            checkOutput("bp_rsp_err", qif.rsp_err, 1'b0);
            acceptRsp();
            stepCycle();
        end
        checkOutput("bp_range_pulses", rangeLoLog.size(), 3);
        for (int i = 0; i < 3; i++) begin
            checkOutput("bp_order_range_lo", (i < rangeLoLog.size()) ? rangeLoLog[i] : 32'hDEAD_BEEF, 32'(100 + i));
        end
        checkOutput("bp_drained_busy", busy, 1'b0);
        checkOutput("bp_drained_req_ready", qif.req_ready, 1'b1);

        // UPDATE_END: one-cycle strobe, response after edge N+3
        applyStimulus(3'd4, 32'd42, 32'd0, 3'b000);
        stepCycle();
        checkOutput("upd_prev_end", previousEnd, 32'd42);
        checkOutput("upd_strobe_setup", updateEnd, 1'b0);
        stepCycle();
        checkOutput("upd_strobe_high", updateEnd, 1'b1);
        checkOutput("upd_rsp_early", qif.rsp_valid, 1'b0);
        stepCycle();
        checkOutput("upd_strobe_low", updateEnd, 1'b0);
        checkOutput("upd_rsp_valid", qif.rsp_valid, 1'b1);
        checkOutput("upd_data0", qif.rsp_data0, 32'd42);
        checkOutput("upd_data1", qif.rsp_data1, 32'd0);
        checkOutput("upd_op", qif.rsp_op, 3'd4);
        checkOutput("upd_strobe_count", updateStrobes, 1);
        acceptRsp();

        // Illegal op: no strobe, error response
        strobeSnapshot = timeStrobes + singleStrobes + recallStrobes + updateStrobes + rangeLoLog.size();
        applyStimulus(3'd6, 32'd5, 32'd7, 3'b111);
        stepCycle();
        checkOutput("ill_rsp_valid", qif.rsp_valid, 1'b1);
        checkOutput("ill_err", qif.rsp_err, 1'b1);
        checkOutput("ill_data", {qif.rsp_data0, qif.rsp_data1}, 64'd0);
        checkOutput("ill_op", qif.rsp_op, 3'd6);
        checkOutput("ill_value_in_kept", valueIn, 32'd3);
        acceptRsp();
        repeat (3) stepCycle();
        checkOutput("ill_no_strobe", timeStrobes + singleStrobes + recallStrobes + updateStrobes + rangeLoLog.size(), strobeSnapshot);

        // SINGLE with a negative tracker result passed through unchanged
        applyStimulus(3'd2, 32'd5, 32'd9, 3'b000);
        stepCycle();
        checkOutput("single_range_lo", rangeLo, 32'd5);
        checkOutput("single_range_hi", rangeHi, 32'd9);
        waitRsp("single_rsp_timeout");
        checkOutput("single_data0", qif.rsp_data0, 32'hFFFF_FFFD);
        acceptRsp();

        // RECALL returns the zero-extended recalled signal
        applyStimulus(3'd3, 32'd7, 32'd0, 3'b000);
        stepCycle();
        checkOutput("recall_cycles_back", cyclesBack, 32'd7);
        waitRsp("recall_rsp_timeout");
        checkOutput("recall_data0", qif.rsp_data0, 32'd1);
        acceptRsp();
        checkOutput("recall_strobe_count", recallStrobes, 1);

        // Reset during SETTLE of a SINGLE query with a RECALL queued behind it
        applyStimulus(3'd2, 32'd11, 32'd12, 3'b000);
        applyStimulus(3'd3, 32'd8, 32'd0, 3'b000);
        stepCycle();
        checkOutput("mid_single_strobe", recalcSingle, 1'b1);
        stepCycle();
        checkOutput("mid_settle_strobe_low", recalcSingle, 1'b0);
        #2;
        rst_n = 1'b1;
        #1;
        rspValidCycles = 0;
        checkOutput("mid_rst_rsp_valid", qif.rsp_valid, 1'b0);
        checkOutput("mid_rst_strobes", {recalcTime, recalcRange, recalcSingle, recalcBack, updateEnd}, 5'b0);
        checkOutput("mid_rst_req_ready", qif.req_ready, 1'b0);
        checkOutput("mid_rst_busy", busy, 1'b0);
        repeat (2) stepCycle();
        rst_n = 1'b0;
        repeat (10) stepCycle();
        checkOutput("mid_no_response", rspValidCycles, 0);
        checkOutput("mid_no_recall_strobe", recallStrobes, 1);
        checkOutput("mid_single_strobes", singleStrobes, 2);
        checkOutput("mid_fifo_empty_busy", busy, 1'b0);
        checkOutput("mid_req_ready", qif.req_ready, 1'b1);
        checkOutput("no_overlapping_strobes", overlapCount, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
